// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if
//   Groups the sequencer's program-memory read bus and its decoder link.
//
//   Program memory handshake (valid/ready style):
//     prog_req   - sequencer wants the byte at prog_addr. It holds prog_req and
//                  prog_addr steady until the transfer completes.
//     prog_valid - memory has prog_data ready. A transfer completes on the
//                  rising clk edge where prog_req & prog_valid are both 1.
//                  prog_valid with prog_req=0 has no effect. Wait states are
//                  unbounded.
//
//   Decoder link: opcode/operand go out to the decoder. jump_operation,
//   jump_condition and ram_operand come back and are sampled at the end of
//   the DECODE cycle.
//
//   Modports: master = sequencer side, slave = memory/decoder side.
interface cpu_sequencer_if #(
  parameter int PC_W = 8
);
  logic            prog_req;
  logic [PC_W-1:0] prog_addr;
  logic [7:0]      prog_data;
  logic            prog_valid;
  logic [7:0]      opcode;
  logic [7:0]      operand;
  logic            jump_operation;
  logic            jump_condition;
  logic            ram_operand;
  logic            exec_strobe;
  logic            wb_strobe;

  modport master (
    output prog_req, prog_addr, opcode, operand, exec_strobe, wb_strobe,
    input  prog_data, prog_valid, jump_operation, jump_condition, ram_operand
  );

  modport slave (
    input  prog_req, prog_addr, opcode, operand, exec_strobe, wb_strobe,
    output prog_data, prog_valid, jump_operation, jump_condition, ram_operand
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer
//   Fetch/execute controller for the 8-bit CPU core. It owns the program
//   counter and runs the cycle FETCH -> DECODE -> [OPERAND] -> EXECUTE ->
//   WRITEBACK. It applies taken jumps in EXECUTE and issues one-cycle
//   exec/writeback strobes to the datapath.
//
// Ports:
//   clk, rst_n  - clock (rising edge), asynchronous active-low reset
//   run         - 1 starts and continues execution. When dropped, the current
//                 instruction finishes first.
//   bus         - cpu_sequencer_if.master: program memory read bus,
//                 opcode/operand to the decoder, decoder flags, strobes
//   pc          - current program counter (also drives bus.prog_addr)
//   state       - FSM state code, for debug
//   halted      - 1 while parked on the halt opcode
//   retired     - count of completed instructions, wraps at 16 bits
module cpu_sequencer #(
  parameter int          PC_W        = 8,
  parameter int unsigned RESET_PC    = 0,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  cpu_sequencer_if.master bus,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      state,
  output logic            halted,
  output logic [15:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_OPERAND   = 3'd3,
    S_EXECUTE   = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      opcode_q, opcode_d;
  logic [7:0]      operand_q, operand_d;
  logic [15:0]     retired_q, retired_d;

  logic prog_req;
  logic exec_strobe;
  logic wb_strobe;
  logic halted_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= PC_W'(RESET_PC);
      opcode_q  <= 8'h00;
      operand_q <= 8'h00;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      retired_q <= retired_d;
    end
  end

  // The strobes, prog_req and halted decode only from state_q. Reset
  // therefore clears them at once, with no clock edge needed.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    opcode_d    = opcode_q;
    operand_d   = operand_q;
    retired_d   = retired_q;
    prog_req    = 1'b0;
    exec_strobe = 1'b0;
    wb_strobe   = 1'b0;
    halted_o    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        prog_req = 1'b1;
        if (bus.prog_valid) begin
          opcode_d = bus.prog_data;
          pc_d     = pc_q + PC_W'(1);
          state_d  = S_DECODE;
        end
      end
      // One settle cycle for the decoder. Its flags are read on the edge
      // that leaves DECODE. Halt takes priority over the operand flags.
      S_DECODE: begin
        if (opcode_q == HALT_OPCODE)
          state_d = S_HALT;
        else if (bus.jump_operation || bus.ram_operand)
          state_d = S_OPERAND;
        else
          state_d = S_EXECUTE;
      end
      S_OPERAND: begin
        prog_req = 1'b1;
        if (bus.prog_valid) begin
          operand_d = bus.prog_data;
          pc_d      = pc_q + PC_W'(1);
          state_d   = S_EXECUTE;
        end
      end
      // A taken jump replaces the already-incremented pc. The decoder
      // flags are still held from DECODE at this point.
      S_EXECUTE: begin
        exec_strobe = 1'b1;
        if (bus.jump_operation && bus.jump_condition)
          pc_d = operand_q[PC_W-1:0];
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        wb_strobe = 1'b1;
        retired_d = retired_q + 16'd1;
        state_d   = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted_o = 1'b1;
        if (!run) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.prog_req    = prog_req;
  assign bus.prog_addr   = pc_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.exec_strobe = exec_strobe;
  assign bus.wb_strobe   = wb_strobe;

  assign pc      = pc_q;
  assign state   = state_q;
  assign halted  = halted_o;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer
//   Directed bench for cpu_sequencer. The bench plays both program memory
//   (with programmable wait states) and the decoder (flag values are set per
//   test). An instruction-level model checks each retired instruction. The
//   same per-cycle process also checks the bus rules. Hand-computed literals
//   pin the individual scenarios.
module tb_cpu_sequencer;
  localparam int PC_W = 8;

  logic            clk;
  logic            rst_n;
  logic            run;
  logic [PC_W-1:0] pc;
  logic [2:0]      state;
  logic            halted;
  logic [15:0]     retired;

  cpu_sequencer_if #(.PC_W(PC_W)) bus ();

  cpu_sequencer #(.PC_W(PC_W), .RESET_PC(0), .HALT_OPCODE(8'hFF)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .bus     (bus),
    .pc      (pc),
    .state   (state),
    .halted  (halted),
    .retired (retired)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory + decoder stand-in ----------------
  logic [7:0] mem [256];
  int         wait_n = 0;
  int         wcnt   = 0;
  logic       stray  = 1'b0;   // drive prog_valid while no request is open
  logic       jop, jcond, ramop;

  assign bus.jump_operation = jop;
  assign bus.jump_condition = jcond;
  assign bus.ram_operand    = ramop;

  always @(negedge clk) begin
    if (bus.prog_req) begin
      if (wcnt >= wait_n) begin
        bus.prog_valid = 1'b1;
        bus.prog_data  = mem[bus.prog_addr];
        wcnt = 0;
      end else begin
        bus.prog_valid = 1'b0;
        bus.prog_data  = 8'h00;
        wcnt++;
      end
    end else begin
      wcnt = 0;
      bus.prog_valid = stray;
      bus.prog_data  = stray ? 8'hAA : 8'h00;
    end
  end

  // ---------------- instruction-level model ----------------
  logic [7:0]  m_pc;
  logic [7:0]  m_operand;
  logic [15:0] m_retired;

  task automatic model_reset();
    m_pc      = 8'h00;
    m_operand = 8'h00;
    m_retired = 16'h0000;
  endtask

  // One whole instruction, as the programmer sees it. Called when the DUT
  // shows its writeback strobe, so pc already holds its final value.
  task automatic model_retire();
    logic [7:0] op;
    op   = mem[m_pc];
    m_pc = m_pc + 8'd1;
    if (jop || ramop) begin
      m_operand = mem[m_pc];
      m_pc      = m_pc + 8'd1;
    end
    if (jop && jcond) m_pc = m_operand;
    check("model_opcode",  {24'h0, bus.opcode},  {24'h0, op});
    check("model_operand", {24'h0, bus.operand}, {24'h0, m_operand});
    check("model_pc",      {24'h0, pc},          {24'h0, m_pc});
    check("model_retired", {16'h0, retired},     {16'h0, m_retired});
    m_retired = m_retired + 16'd1;
  endtask

  // The halt opcode is consumed (pc moves past it) but not retired.
  task automatic model_halt();
    check("model_halt_opcode", {24'h0, bus.opcode}, {24'h0, mem[m_pc]});
    m_pc = m_pc + 8'd1;
    check("model_halt_pc",      {24'h0, pc},      {24'h0, m_pc});
    check("model_halt_retired", {16'h0, retired}, {16'h0, m_retired});
  endtask

  // ---------------- per-cycle compare process ----------------
  logic prev_exec   = 1'b0;
  logic prev_halted = 1'b0;
  int   cnt_req = 0, cnt_exec = 0, cnt_wb = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_exec   = 1'b0;
      prev_halted = 1'b0;
    end else begin
      if (bus.prog_req) check("prog_addr_eq_pc", {24'h0, bus.prog_addr}, {24'h0, pc});
      if (prev_exec) check("wb_after_exec", {31'h0, bus.wb_strobe}, 32'd1);
      if (halted) check("halt_no_req", {31'h0, bus.prog_req | bus.exec_strobe | bus.wb_strobe}, 32'd0);
      if (bus.wb_strobe) model_retire();
      if (halted && !prev_halted) model_halt();
      cnt_req  += int'(bus.prog_req);
      cnt_exec += int'(bus.exec_strobe);
      cnt_wb   += int'(bus.wb_strobe);
      prev_exec   = bus.exec_strobe;
      prev_halted = halted;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (state == 3'd0) break;
    end
    check("reach_idle", {29'h0, state}, 32'd0);
  endtask

  // Run exactly one instruction: pulse run, then let the FSM return to IDLE.
  task automatic step();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_idle();
  endtask

  task automatic set_flags(input logic j, input logic c, input logic r);
    jop = j; jcond = c; ramop = r;
  endtask

  // ---------------- scoreboard queue for state sequences ----------------
  logic [2:0] exp_q[$];

  // ---------------- directed tests ----------------
  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    bus.prog_valid = 1'b0;
    bus.prog_data  = 8'h00;
    set_flags(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    model_reset();

    // reset state, asserted from time 0
    repeat (2) @(negedge clk);
    check("rst_state",   {29'h0, state},       32'd0);
    check("rst_pc",      {24'h0, pc},          32'd0);
    check("rst_opcode",  {24'h0, bus.opcode},  32'd0);
    check("rst_operand", {24'h0, bus.operand}, 32'd0);
    check("rst_req",     {31'h0, bus.prog_req}, 32'd0);
    check("rst_retired", {16'h0, retired},     32'd0);
    rst_n = 1'b1;

    // 1: one-byte instruction, no wait states, state sequence
    wait_n = 0;
    exp_q = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd1};
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_state", {29'h0, state}, {29'h0, exp_q.pop_front()});
      if (i == 2) check("t1_exec", {31'h0, bus.exec_strobe}, 32'd1);
      if (i == 3) check("t1_pc", {24'h0, pc}, 32'd1);
    end
    check("t1_retired", {16'h0, retired}, 32'd1);
    run = 1'b0;
    wait_idle();

    // 2: operand instruction with 2 wait cycles per read
    do_reset();
    mem[0] = 8'h10; mem[1] = 8'h5A;
    set_flags(1'b0, 1'b0, 1'b1);
    wait_n = 2;
    cnt_req = 0; cnt_exec = 0; cnt_wb = 0;
    step();
    check("t2_req_cycles", cnt_req, 32'd6);
    check("t2_exec_cnt",   cnt_exec, 32'd1);
    check("t2_wb_cnt",     cnt_wb, 32'd1);
    check("t2_operand",    {24'h0, bus.operand}, 32'h5A);
    check("t2_pc",         {24'h0, pc}, 32'd2);
    wait_n = 0;

    // 3: taken jump, then the next fetch comes from the target
    do_reset();
    mem[0] = 8'h20; mem[1] = 8'h40; mem[8'h40] = 8'h00;
    set_flags(1'b1, 1'b1, 1'b0);
    step();
    check("t3_pc_taken", {24'h0, pc}, 32'h40);
    set_flags(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    check("t3_fetch_req",  {31'h0, bus.prog_req}, 32'd1);
    check("t3_fetch_addr", {24'h0, bus.prog_addr}, 32'h40);
    wait_idle();
    // jump not taken
    do_reset();
    set_flags(1'b1, 1'b0, 1'b0);
    step();
    check("t3_pc_not_taken", {24'h0, pc}, 32'd2);

    // 4: halt opcode
    do_reset();
    mem[0] = 8'hFF;
    set_flags(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("t4_halted", {31'h0, halted}, 32'd1);
    stray = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_halt_hold", {30'h0, halted, bus.prog_req}, 32'b10);
    end
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("t4_state",   {29'h0, state}, 32'd0);
    check("t4_pc",      {24'h0, pc}, 32'd1);
    check("t4_retired", {16'h0, retired}, 32'd0);
    check("t4_stray_ignored", {24'h0, bus.opcode}, 32'hFF);
    stray = 1'b0;

    // 5: pc wrap on a one-byte and on a two-byte instruction
    do_reset();
    mem[0] = 8'h20; mem[1] = 8'hFF; mem[8'hFF] = 8'h01;
    set_flags(1'b1, 1'b1, 1'b0);
    step();
    check("t5_pc_ff", {24'h0, pc}, 32'hFF);
    set_flags(1'b0, 1'b0, 1'b0);
    step();
    check("t5_wrap_1byte", {24'h0, pc}, 32'h00);
    set_flags(1'b1, 1'b1, 1'b0);
    step();
    mem[8'hFF] = 8'h30;
    set_flags(1'b0, 1'b0, 1'b1);
    step();
    check("t5_wrap_2byte_pc",  {24'h0, pc}, 32'h01);
    check("t5_wrap_2byte_opd", {24'h0, bus.operand}, 32'h20);

    // 6: asynchronous reset in the middle of an operand fetch
    do_reset();
    mem[0] = 8'h10; mem[1] = 8'h99;
    set_flags(1'b0, 1'b0, 1'b1);
    wait_n = 5;
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state == 3'd3) break;
    end
    check("t6_in_operand", {30'h0, state == 3'd3, bus.prog_req}, 32'b11);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_async_req",   {31'h0, bus.prog_req}, 32'd0);
    check("t6_async_state", {29'h0, state}, 32'd0);
    check("t6_async_pc",    {24'h0, pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_n = 0;
    step();
    check("t6_restart_pc",  {24'h0, pc}, 32'd2);
    check("t6_restart_opd", {24'h0, bus.operand}, 32'h99);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit. On expiry it prints a FAIL line and the summary.
  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
